crc_decoding: RTL and testbench

Receive-side counterpart of the token/data CRC encoder in the USB host path. Accepts the serial bit stream after NRZI decode and bit unstuffing, deserializes PID and body fields, runs CRC5 (token) or CRC16 (data) checks on the fly, and presents a parsed packet with a one-cycle valid or error pulse to the protocol FSM.

---
 rtl/crc_decoding.sv | 190 +++++++++++++++++++
 tb/tb_crc_decoding.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_decoding.sv
// Receive-side USB packet parser: deserialises PID and body, checks PID format and CRC5/CRC16 on the fly.
// Latency: eop sampled in cycle N gives the one-cycle pktValid/pktErr pulse in cycle N+1; busy drops in N+2.
// Backpressure: none; a bit is consumed only when bInValid is high, stall gaps of any length are tolerated.
module crc_decoding (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        sop,
    input  logic        bIn,
    input  logic        bInValid,
    input  logic        eop,
    output logic        pktValid,
    output logic        pktErr,
    output logic [2:0]  errCode,
    output logic [1:0]  pktType,
    output logic [3:0]  pid,
    output logic [6:0]  addr,
    output logic [3:0]  endp,
    output logic [63:0] data,
    output logic        busy
);

    typedef enum logic [2:0] {ST_IDLE, ST_PID, ST_BODY, ST_DRAIN, ST_DONE} state_t;

    state_t      state;
    logic [7:0]  pid_reg;
    logic [63:0] body;      // CRC16 bits only feed the checker, so only the payload span is kept
    logic [6:0]  bit_cnt;
    logic [4:0]  crc5;
    logic [15:0] crc16;
    logic [2:0]  err_lat;

    logic [7:0]  pid_nxt;
    logic [63:0] body_nxt;
    logic [6:0]  cnt_nxt;
    logic [6:0]  exp_len;
    logic [6:0]  body_len;
    logic [4:0]  crc5_nxt;
    logic [15:0] crc16_nxt;
    logic        fb5;
    logic        fb16;
    logic        pid_done;
    logic [2:0]  pid_code;
    logic [2:0]  chk_code;
    logic        fin;
    logic [2:0]  fin_code;

    always_comb begin
        pid_nxt   = pid_reg;
        body_nxt  = body;
        crc5_nxt  = crc5;
        crc16_nxt = crc16;
        fb5       = bIn ^ crc5[4];
        fb16      = bIn ^ crc16[15];
        cnt_nxt   = bit_cnt + {6'd0, bInValid};
        if (state == ST_PID && bInValid)
            pid_nxt[bit_cnt[2:0]] = bIn;
        if (state == ST_BODY && bInValid) begin
            crc5_nxt  = {crc5[3:0], 1'b0} ^ (fb5 ? 5'b00101 : 5'b00000);
            crc16_nxt = {crc16[14:0], 1'b0} ^ (fb16 ? 16'h8005 : 16'h0000);
            if (bit_cnt < 7'd64)
                body_nxt[bit_cnt[5:0]] = bIn;
        end

        pid_done = (state == ST_PID) && bInValid && (bit_cnt == 7'd7);

        pid_code = 3'b000;
        if (pid_nxt[7:4] != ~pid_nxt[3:0])
            pid_code = 3'b001;
        else begin
            case (pid_nxt[3:0])
                4'b0001, 4'b1001, 4'b0011, 4'b1011, 4'b0010, 4'b1010: pid_code = 3'b000;
                default:                                              pid_code = 3'b100;
            endcase
        end

        case (pid_nxt[1:0])
            2'b01:   exp_len = 7'd16;
            2'b11:   exp_len = 7'd80;
            default: exp_len = 7'd0;
        endcase

        // A PID that completes together with eop has an empty body
        body_len = (state == ST_BODY) ? cnt_nxt : 7'd0;

        chk_code = 3'b000;
        if (body_len != exp_len)
            chk_code = 3'b010;
        else if (pid_nxt[1:0] == 2'b01 && crc5_nxt != 5'b01100)
            chk_code = 3'b011;
        else if (pid_nxt[1:0] == 2'b11 && crc16_nxt != 16'h800D)
            chk_code = 3'b011;

        fin      = 1'b0;
        fin_code = 3'b000;
        case (state)
            ST_PID: if (eop) begin
                fin      = 1'b1;
                fin_code = !pid_done ? 3'b010 : ((pid_code != 3'b000) ? pid_code : chk_code);
            end
            ST_BODY: if (eop) begin
                fin      = 1'b1;
                fin_code = chk_code;
            end
            ST_DRAIN: if (eop) begin
                fin      = 1'b1;
                fin_code = err_lat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= ST_IDLE;
            pid_reg  <= 8'd0;
            body     <= 64'd0;
            bit_cnt  <= 7'd0;
            crc5     <= 5'h1F;
            crc16    <= 16'hFFFF;
            err_lat  <= 3'b000;
            pktValid <= 1'b0;
            pktErr   <= 1'b0;
            errCode  <= 3'b000;
            pktType  <= 2'b00;
            pid      <= 4'd0;
            addr     <= 7'd0;
            endp     <= 4'd0;
            data     <= 64'd0;
            busy     <= 1'b0;
        end else begin
            pktValid <= 1'b0;
            pktErr   <= 1'b0;
            if (sop) begin
                // sop always restarts, abandoning any packet in flight without a pulse
                state   <= ST_PID;
                busy    <= 1'b1;
                pid_reg <= 8'd0;
                body    <= 64'd0;
                bit_cnt <= 7'd0;
                crc5    <= 5'h1F;
                crc16   <= 16'hFFFF;
                err_lat <= 3'b000;
            end else if (fin) begin
                state    <= ST_DONE;
                pid_reg  <= pid_nxt;
                body     <= body_nxt;
                pktValid <= (fin_code == 3'b000);
                pktErr   <= (fin_code != 3'b000);
                errCode  <= fin_code;
                pktType  <= pid_nxt[1:0];
                pid      <= pid_nxt[3:0];
                addr     <= body_nxt[6:0];
                endp     <= body_nxt[10:7];
                data     <= body_nxt;
            end else begin
                case (state)
                    ST_PID: begin
                        pid_reg <= pid_nxt;
                        bit_cnt <= cnt_nxt;
                        if (pid_done) begin
                            bit_cnt <= 7'd0;
                            if (pid_code != 3'b000) begin
                                err_lat <= pid_code;
                                state   <= ST_DRAIN;
                            end else begin
                                state <= ST_BODY;
                            end
                        end
                    end
                    ST_BODY: begin
                        body    <= body_nxt;
                        bit_cnt <= cnt_nxt;
                        crc5    <= crc5_nxt;
                        crc16   <= crc16_nxt;
                        if (cnt_nxt > exp_len) begin
                            err_lat <= 3'b010;
                            state   <= ST_DRAIN;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc_decoding.sv
// Bench for crc_decoding: directed packets plus randomized traffic checked against a field-level packet model.
module tb_crc_decoding;

    logic        clk;
    logic        rst_b;
    logic        sop;
    logic        bIn;
    logic        bInValid;
    logic        eop;
    logic        pktValid;
    logic        pktErr;
    logic [2:0]  errCode;
    logic [1:0]  pktType;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    logic        busy;

    crc_decoding dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .sop      (sop),
        .bIn      (bIn),
        .bInValid (bInValid),
        .eop      (eop),
        .pktValid (pktValid),
        .pktErr   (pktErr),
        .errCode  (errCode),
        .pktType  (pktType),
        .pid      (pid),
        .addr     (addr),
        .endp     (endp),
        .data     (data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    int vld0;
    int err0;
    int snap;
    string step = "";

    logic        tx[$];
    logic [2:0]  exp_code;
    logic [3:0]  exp_pid;
    logic [6:0]  exp_addr;
    logic [3:0]  exp_endp;
    logic [63:0] exp_data;

    always @(negedge clk) begin
        if (pktValid === 1'b1) vld_cnt++;
        if (pktErr === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed=%0h expected=%0h", step, tag, obs, exp);
        end
    endtask

    // Bit-serial division with all-ones preset; the transmitted CRC is its complement, MSB first
    function automatic logic [15:0] crc_over(input int first, input int count, input int width, input int poly);
        int mask;
        int r;
        int hi;
        mask = (1 << width) - 1;
        r = mask;
        for (int i = 0; i < count; i++) begin
            hi = (r >> (width - 1)) & 1;
            r = (r << 1) & mask;
            if ((hi ^ int'(tx[first + i])) != 0) r = r ^ poly;
        end
        return 16'(r);
    endfunction

    function automatic logic [63:0] bits_lsb(input int first, input int w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < w; i++)
            if (first + i < tx.size()) v[i] = tx[first + i];
        return v;
    endfunction

    function automatic logic [15:0] bits_msb(input int first, input int w);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < w; i++) v = {v[14:0], tx[first + i]};
        return v;
    endfunction

    task automatic push_bits(input logic [63:0] v, input int w, input bit msb_first);
        for (int i = 0; i < w; i++) tx.push_back(msb_first ? v[w - 1 - i] : v[i]);
    endtask

    task automatic push_pid(input logic [3:0] p);
        push_bits({56'd0, ~p, p}, 8, 1'b0);
    endtask

    task automatic make_token(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                              input logic [4:0] crc, input bit auto_crc);
        logic [15:0] c;
        tx.delete();
        push_pid(p);
        push_bits({57'd0, a}, 7, 1'b0);
        push_bits({60'd0, e}, 4, 1'b0);
        c = auto_crc ? ~crc_over(8, 11, 5, 5'h05) : {11'd0, crc};
        push_bits({48'd0, c}, 5, 1'b1);
    endtask

    task automatic make_data(input logic [3:0] p, input logic [63:0] d);
        logic [15:0] c;
        tx.delete();
        push_pid(p);
        push_bits(d, 64, 1'b0);
        c = ~crc_over(8, 64, 16, 16'h8005);
        push_bits({48'd0, c}, 16, 1'b1);
    endtask

    task automatic flip(input int idx);
        tx[idx] = ~tx[idx];
    endtask

    // Packet-level reference: decides the outcome from PID rules, body lengths and recomputed CRC fields
    task automatic model();
        int n;
        int need;
        logic [7:0] pb;
        n = tx.size();
        pb = bits_lsb(0, 8)[7:0];
        exp_pid  = pb[3:0];
        exp_addr = bits_lsb(8, 7)[6:0];
        exp_endp = bits_lsb(15, 4)[3:0];
        exp_data = bits_lsb(8, 64);
        exp_code = 3'd0;
        if (n < 8)
            exp_code = 3'd2;
        else if (pb[7:4] != ~pb[3:0])
            exp_code = 3'd1;
        else if (!(pb[3:0] inside {4'b0001, 4'b1001, 4'b0011, 4'b1011, 4'b0010, 4'b1010}))
            exp_code = 3'd4;
        else begin
            need = (pb[1:0] == 2'b01) ? 16 : (pb[1:0] == 2'b11) ? 80 : 0;
            if (n - 8 != need)
                exp_code = 3'd2;
            else if (need == 16 && bits_msb(19, 5) != ((~crc_over(8, 11, 5, 5'h05)) & 16'h001F))
                exp_code = 3'd3;
            else if (need == 80 && bits_msb(72, 16) != ~crc_over(8, 64, 16, 16'h8005))
                exp_code = 3'd3;
        end
    endtask

    task automatic send(input int gap_pct, input bit eop_last);
        int n;
        n = tx.size();
        vld0 = vld_cnt;
        err0 = err_cnt;
        sop = 1'b1;
        eop = 1'b0;
        bInValid = 1'($urandom);
        bIn = 1'($urandom);
        @(posedge clk); #1;
        sop = 1'b0;
        bInValid = 1'b0;
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                bInValid = 1'b0;
                bIn = 1'($urandom);
                @(posedge clk); #1;
            end
            bIn = tx[i];
            bInValid = 1'b1;
            eop = eop_last && (i == n - 1);
            @(posedge clk); #1;
        end
        bInValid = 1'b0;
        if (!(eop_last && n > 0)) begin
            eop = 1'b1;
            @(posedge clk); #1;
        end
        eop = 1'b0;
    endtask

    task automatic check_pulse();
        model();
        chk("pktValid", pktValid, exp_code == 3'd0);
        chk("pktErr", pktErr, exp_code != 3'd0);
        chk("errCode", errCode, exp_code);
        chk("busy_done", busy, 1'b1);
        if (tx.size() >= 8) begin
            chk("pid", pid, exp_pid);
            chk("pktType", pktType, exp_pid[1:0]);
        end
        if (exp_code == 3'd0 && exp_pid[1:0] == 2'b01) begin
            chk("addr", addr, exp_addr);
            chk("endp", endp, exp_endp);
        end
        if (exp_code == 3'd0 && exp_pid[1:0] == 2'b11)
            chk("data", data, exp_data);
    endtask

    task automatic check_after();
        @(posedge clk); #1;
        chk("busy_idle", busy, 1'b0);
        chk("n_valid_pulses", vld_cnt - vld0, exp_code == 3'd0);
        chk("n_err_pulses", err_cnt - err0, exp_code != 3'd0);
        chk("errCode_hold", errCode, exp_code);
        if (exp_code == 3'd0 && exp_pid[1:0] == 2'b01)
            chk("addr_hold", addr, exp_addr);
    endtask

    initial begin
        int kind;
        rst_b = 1'b0;
        sop = 1'b0;
        bIn = 1'b0;
        bInValid = 1'b0;
        eop = 1'b0;

        step = "reset";
        repeat (2) @(posedge clk);
        #1;
        chk("ctl_outs", {pktValid, pktErr, errCode, pktType, pid, addr, endp, busy}, 23'd0);
        chk("data_out", data, 64'd0);
        rst_b = 1'b1;
        @(posedge clk); #1;

        step = "out_token";
        make_token(4'b0001, 7'h15, 4'hE, 5'b10111, 1'b0);
        send(0, 1'b0);
        check_pulse();
        chk("addr_plan", addr, 7'h15);
        chk("endp_plan", endp, 4'hE);
        chk("type_plan", pktType, 2'b01);
        chk("code_plan", errCode, 3'b000);
        check_after();

        step = "token_addr_flip";
        make_token(4'b0001, 7'h15, 4'hE, 5'b10111, 1'b0);
        flip(11);
        send(20, 1'b0);
        check_pulse();
        chk("code_plan", errCode, 3'b011);
        check_after();

        for (int b = 0; b < 5; b++) begin
            step = $sformatf("token_crc_flip%0d", b);
            make_token(4'b1001, 7'($urandom), 4'($urandom), 5'd0, 1'b1);
            flip(19 + b);
            send(30, 1'b1);
            check_pulse();
            check_after();
        end

        step = "data0_seq";
        make_data(4'b0011, 64'h0706050403020100);
        send(40, 1'b0);
        check_pulse();
        chk("data_plan", data, 64'h0706050403020100);
        check_after();

        step = "data0_badcrc";
        make_data(4'b0011, 64'h0706050403020100);
        flip(72 + $urandom_range(15));
        send(40, 1'b1);
        check_pulse();
        chk("code_plan", errCode, 3'b011);
        check_after();

        step = "ack";
        tx.delete();
        push_pid(4'b0010);
        send(10, 1'b0);
        check_pulse();
        chk("type_plan", pktType, 2'b10);
        check_after();

        step = "ack_extra";
        tx.delete();
        push_pid(4'b0010);
        push_bits(64'h5, 3, 1'b0);
        send(10, 1'b0);
        check_pulse();
        chk("code_plan", errCode, 3'b010);
        check_after();

        step = "short_pid";
        tx.delete();
        push_pid(4'b0010);
        repeat (3) void'(tx.pop_back());
        send(10, 1'b0);
        check_pulse();
        chk("code_plan", errCode, 3'b010);
        check_after();

        step = "pid_check";
        tx.delete();
        push_bits(64'hE0, 8, 1'b0);
        repeat (12) tx.push_back(1'($urandom));
        send(10, 1'b0);
        check_pulse();
        chk("code_plan", errCode, 3'b001);
        check_after();

        step = "setup_pid";
        tx.delete();
        push_pid(4'b1101);
        repeat (16) tx.push_back(1'($urandom));
        send(10, 1'b0);
        check_pulse();
        chk("code_plan", errCode, 3'b100);
        check_after();

        step = "abort_restart";
        snap = vld_cnt + err_cnt;
        make_token(4'b0001, 7'h2A, 4'h3, 5'd0, 1'b1);
        sop = 1'b1;
        @(posedge clk); #1;
        sop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bIn = tx[i];
            bInValid = 1'b1;
            @(posedge clk); #1;
        end
        bInValid = 1'b0;
        make_token(4'b1001, 7'h33, 4'h9, 5'd0, 1'b1);
        send(10, 1'b0);
        check_pulse();
        check_after();
        chk("total_pulses", vld_cnt + err_cnt - snap, 1);

        step = "back_to_back";
        snap = vld_cnt;
        make_token(4'b0001, 7'($urandom), 4'($urandom), 5'd0, 1'b1);
        send(0, 1'b1);
        check_pulse();
        make_token(4'b1001, 7'($urandom), 4'($urandom), 5'd0, 1'b1);
        send(0, 1'b0);
        check_pulse();
        @(posedge clk); #1;
        chk("busy_idle", busy, 1'b0);
        chk("valid_pulses", vld_cnt - snap, 2);

        step = "reset_mid";
        snap = vld_cnt + err_cnt;
        make_data(4'b1011, {$urandom, $urandom});
        sop = 1'b1;
        @(posedge clk); #1;
        sop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bIn = tx[i];
            bInValid = 1'b1;
            @(posedge clk); #1;
        end
        bInValid = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("ctl_outs", {pktValid, pktErr, errCode, pktType, pid, addr, endp, busy}, 23'd0);
        chk("data_out", data, 64'd0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        eop = 1'b1;
        @(posedge clk); #1;
        eop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("no_pulse", vld_cnt + err_cnt - snap, 0);
        chk("busy_idle", busy, 1'b0);

        for (int k = 0; k < 60; k++) begin
            step = $sformatf("rand%0d", k);
            kind = int'($urandom_range(5));
            case (kind)
                0: make_token($urandom_range(1) ? 4'b1001 : 4'b0001, 7'($urandom), 4'($urandom), 5'd0, 1'b1);
                1: begin
                    make_token($urandom_range(1) ? 4'b1001 : 4'b0001, 7'($urandom), 4'($urandom), 5'd0, 1'b1);
                    flip(8 + int'($urandom_range(15)));
                end
                2: make_data($urandom_range(1) ? 4'b1011 : 4'b0011, {$urandom, $urandom});
                3: begin
                    make_data($urandom_range(1) ? 4'b1011 : 4'b0011, {$urandom, $urandom});
                    flip(8 + int'($urandom_range(79)));
                end
                4: begin
                    tx.delete();
                    push_pid($urandom_range(1) ? 4'b0010 : 4'b1010);
                    repeat ($urandom_range(2)) tx.push_back(1'($urandom));
                end
                default: begin
                    tx.delete();
                    repeat ($urandom_range(30)) tx.push_back(1'($urandom));
                end
            endcase
            if (kind < 4 && $urandom_range(7) == 0) void'(tx.pop_back());
            if (kind < 4 && $urandom_range(7) == 0) tx.push_back(1'($urandom));
            send(int'($urandom_range(50)), 1'($urandom));
            check_pulse();
            check_after();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
